// File: rtl/led_array_example_pkg.sv
// Shared constants and types for the LED-array pattern source.
package led_array_example_pkg;

    localparam int unsigned LED_W       = 32;
    localparam int unsigned DEFAULT_DIV = 1000;

    typedef logic [LED_W-1:0] led_word_t;

    // A divide ratio of zero makes no sense for a prescaler; run it as divide-by-one.
    function automatic int unsigned eff_div(input int unsigned div);
        return (div == 0) ? 1 : div;
    endfunction

endpackage

// File: rtl/led_array_example_if.sv
// LED-array output bus: the pattern source drives it, the LED/display driver consumes it.
interface led_array_example_if
    import led_array_example_pkg::*;
#(
    parameter int unsigned WIDTH = LED_W
);
    logic [WIDTH-1:0] led_obj_ext_led_array_exp;

    modport master (output led_obj_ext_led_array_exp);
    modport slave  (input  led_obj_ext_led_array_exp);
endinterface

// File: rtl/led_array_example_tick_prescaler.sv
// Divides the clock by DIV and emits a registered one-cycle tick per period.
module tick_prescaler
    import led_array_example_pkg::*;
#(
    parameter int unsigned DIV = DEFAULT_DIV
) (
    input  logic clk,
    input  logic reset_n_sync,
    output logic tick
);
    localparam int unsigned DIV_EFF = eff_div(DIV);
    localparam int          PRE_W   = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;
    localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV_EFF - 1);

    // The edge on which the synchronised reset releases is already the first
    // counted prescaler edge, but the flops only see the release one edge
    // later. They therefore leave reset holding the state that edge would
    // have produced: phase one step in, or a pending tick for divide-by-one.
    localparam logic [PRE_W-1:0] PRE_START  = (DIV_EFF > 1) ? PRE_W'(1) : '0;
    localparam logic             TICK_START = (DIV_EFF == 1);

    logic [PRE_W-1:0] pre;

    // Free-running phase counter; wraps at DIV-1 and raises tick for one cycle.
    always_ff @(posedge clk or negedge reset_n_sync) begin
        if (!reset_n_sync) begin
            pre  <= PRE_START;
            tick <= TICK_START;
        end else if (pre == LAST) begin
            pre  <= '0;
            tick <= 1'b1;
        end else begin
            pre  <= pre + PRE_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/led_array_example.sv
// Self-running LED pattern source: a prescaled counter driven onto the LED bus.
module led_array_example
    import led_array_example_pkg::*;
#(
    parameter int unsigned       WIDTH = LED_W,
    parameter int unsigned       DIV   = DEFAULT_DIV,
    parameter logic [WIDTH-1:0]  STEP  = WIDTH'(1)
) (
    input  logic                clk,
    input  logic                reset,
    led_array_example_if.master led_if
);
    logic [1:0]       sync_q;
    logic             reset_n_sync;
    logic             tick;
    logic [WIDTH-1:0] cnt;

    // Reset synchroniser: asserts immediately, releases after two clock edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign reset_n_sync = sync_q[1];

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk          (clk),
        .reset_n_sync (reset_n_sync),
        .tick         (tick)
    );

    // Count register: advances by STEP per tick, wrapping modulo 2^WIDTH.
    always_ff @(posedge clk or negedge reset_n_sync) begin
        if (!reset_n_sync) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + STEP;
        end
    end

    assign led_if.led_obj_ext_led_array_exp = cnt;

endmodule

// File: tb/tb_led_array_example.sv
// Bench for led_array_example: several configurations share clock and reset,
// each checked against a closed-form model of the expected LED value.
module tb_led_array_example;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #10 clk = ~clk;

    led_array_example_if #(.WIDTH(32)) if4 ();
    led_array_example_if #(.WIDTH(32)) ifdef ();
    led_array_example_if #(.WIDTH(32)) if1 ();
    led_array_example_if #(.WIDTH(4))  ifn ();
    led_array_example_if #(.WIDTH(32)) ifb ();

    led_array_example #(.WIDTH(32), .DIV(4), .STEP(32'd1)) dut4 (
        .clk(clk), .reset(reset), .led_if(if4));
    led_array_example dutdef (
        .clk(clk), .reset(reset), .led_if(ifdef));
    led_array_example #(.WIDTH(32), .DIV(1), .STEP(32'd1)) dut1 (
        .clk(clk), .reset(reset), .led_if(if1));
    led_array_example #(.WIDTH(4), .DIV(2), .STEP(4'd1)) dutn (
        .clk(clk), .reset(reset), .led_if(ifn));
    led_array_example #(.WIDTH(32), .DIV(2), .STEP(32'h4000_0000)) dutb (
        .clk(clk), .reset(reset), .led_if(ifb));

    logic [31:0] o4, odef, o1, ob;
    logic [3:0]  on;
    assign o4   = if4.led_obj_ext_led_array_exp;
    assign odef = ifdef.led_obj_ext_led_array_exp;
    assign o1   = if1.led_obj_ext_led_array_exp;
    assign on   = ifn.led_obj_ext_led_array_exp;
    assign ob   = ifb.led_obj_ext_led_array_exp;

    // Expected LED value after the k-th rising edge following reset release.
    // Edge 2 is E0; the value then changes at E0+DIV, E0+2*DIV, ...
    function automatic logic [31:0] model(input int k, input int div, input logic [31:0] step,
                                          input int w);
        longint      ticks;
        logic [63:0] v;
        logic [63:0] mask;
        int          d;
        d     = (div < 1) ? 1 : div;
        ticks = (k >= 2) ? longint'((k - 2) / d) : 64'sd0;
        v     = 64'(ticks) * 64'(step);
        mask  = (64'd1 << w) - 64'd1;
        v     = v & mask;
        return v[31:0];
    endfunction

    // Release reset between clock edges at a random phase of the low half-cycle.
    task automatic release_reset();
        @(negedge clk);
        #($urandom_range(1, 8));
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #2;
            tests++;
            if (o4 !== 32'd0) begin
                fails++; $display("FAIL reset_hold div4 cycle %0d: got %h want 0", c, o4);
            end
            tests++;
            if (o1 !== 32'd0) begin
                fails++; $display("FAIL reset_hold div1 cycle %0d: got %h want 0", c, o1);
            end
        end
        release_reset();
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #2;
        end
        exp = model(14, 4, 32'd1, 32);
        tests++;
        if (o4 !== exp) begin
            fails++; $display("FAIL reset_prerun div4: got %h want %h", o4, exp);
        end
        // Assert mid-cycle: outputs must clear with no clock edge.
        #3;
        reset = 1'b0;
        #1;
        tests++;
        if (o4 !== 32'd0) begin
            fails++; $display("FAIL reset_async div4: got %h want 0", o4);
        end
        tests++;
        if (o1 !== 32'd0) begin
            fails++; $display("FAIL reset_async div1: got %h want 0", o1);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #2;
            tests++;
            if (o4 !== 32'd0) begin
                fails++; $display("FAIL reset_rehold div4 cycle %0d: got %h want 0", c, o4);
            end
        end
    endtask

    task automatic test_basic_count();
        logic [31:0] exp;
        int          changes;
        logic [31:0] prev;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        release_reset();
        prev    = 32'd0;
        changes = 0;
        for (int k = 1; k <= 2 + 16 + 3; k++) begin
            @(posedge clk); #2;
            exp = model(k, 4, 32'd1, 32);
            tests++;
            if (o4 !== exp) begin
                fails++; $display("FAIL basic_count edge %0d: got %h want %h", k, o4, exp);
            end
            if (o4 !== prev) changes++;
            prev = o4;
        end
        tests++;
        if (o4 !== 32'd4 || changes != 4) begin
            fails++; $display("FAIL basic_count_end: got value %0d after %0d changes want 4 after 4", o4, changes);
        end
    endtask

    task automatic test_default_run();
        logic [31:0] exp;
        logic [31:0] prev;
        int          last_change;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        prev        = 32'd0;
        last_change = 2;
        for (int k = 1; k <= 20000; k++) begin
            @(posedge clk); #2;
            exp = model(k, 1000, 32'd1, 32);
            tests++;
            if (odef !== exp) begin
                fails++; $display("FAIL default_run edge %0d: got %0d want %0d", k, odef, exp);
            end
            if (odef !== prev) begin
                tests++;
                if (odef < prev || (k - last_change) != 1000) begin
                    fails++;
                    $display("FAIL default_spacing edge %0d: got %0d cycles since change want 1000", k, k - last_change);
                end
                last_change = k;
            end
            prev = odef;
        end
        tests++;
        if (odef !== 32'd19) begin
            fails++; $display("FAIL default_final: got %0d want 19", odef);
        end
    endtask

    task automatic test_div1();
        logic [31:0] exp;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #2;
            exp = model(k, 1, 32'd1, 32);
            tests++;
            if (o1 !== exp) begin
                fails++; $display("FAIL div1 edge %0d: got %0d want %0d", k, o1, exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        // 4-bit counter passes 15 -> 0 -> 1; 32-bit large step passes C0000000 -> 0.
        for (int k = 1; k <= 2 + 2 * 18; k++) begin
            @(posedge clk); #2;
            exp = model(k, 2, 32'd1, 4);
            tests++;
            if (on !== exp[3:0]) begin
                fails++; $display("FAIL wrap_narrow edge %0d: got %h want %h", k, on, exp[3:0]);
            end
            exp = model(k, 2, 32'h4000_0000, 32);
            tests++;
            if (ob !== exp) begin
                fails++; $display("FAIL wrap_step edge %0d: got %h want %h", k, ob, exp);
            end
        end
    endtask

    task automatic test_mid_run_reset();
        logic [31:0] exp;
        int          stop_k;
        for (int r = 0; r < 4; r++) begin
            // First pass: stop where cnt=5 and pre=2; later passes stop at random points.
            stop_k = (r == 0) ? 23 : int'($urandom_range(6, 40));
            reset = 1'b0;
            repeat (2) @(posedge clk);
            release_reset();
            for (int k = 1; k <= stop_k; k++) begin
                @(posedge clk); #2;
            end
            exp = model(stop_k, 4, 32'd1, 32);
            tests++;
            if (o4 !== exp) begin
                fails++; $display("FAIL midrun_before pass %0d: got %0d want %0d", r, o4, exp);
            end
            #($urandom_range(1, 6));
            reset = 1'b0;
            #1;
            tests++;
            if (o4 !== 32'd0) begin
                fails++; $display("FAIL midrun_clear pass %0d: got %0d want 0", r, o4);
            end
            repeat ($urandom_range(1, 4)) @(posedge clk);
            release_reset();
            for (int k = 1; k <= 14; k++) begin
                @(posedge clk); #2;
                exp = model(k, 4, 32'd1, 32);
                tests++;
                if (o4 !== exp) begin
                    fails++; $display("FAIL midrun_restart pass %0d edge %0d: got %0d want %0d", r, k, o4, exp);
                end
            end
        end
    endtask

    task automatic test_random_runs();
        logic [31:0] exp;
        int          hold;
        int          len;
        for (int r = 0; r < 5; r++) begin
            reset = 1'b0;
            hold  = int'($urandom_range(1, 6));
            for (int c = 0; c < hold; c++) begin
                @(posedge clk); #2;
                tests++;
                if ({o4, o1, ob, odef} !== 128'd0 || on !== 4'd0) begin
                    fails++; $display("FAIL random_hold run %0d: got %h %h %h %h %h want all 0", r, o4, o1, ob, odef, on);
                end
            end
            release_reset();
            len = int'($urandom_range(10, 60));
            for (int k = 1; k <= len; k++) begin
                @(posedge clk); #2;
                exp = model(k, 4, 32'd1, 32);
                tests++;
                if (o4 !== exp) begin
                    fails++; $display("FAIL random_div4 run %0d edge %0d: got %h want %h", r, k, o4, exp);
                end
                exp = model(k, 1, 32'd1, 32);
                tests++;
                if (o1 !== exp) begin
                    fails++; $display("FAIL random_div1 run %0d edge %0d: got %h want %h", r, k, o1, exp);
                end
                exp = model(k, 2, 32'd1, 4);
                tests++;
                if (on !== exp[3:0]) begin
                    fails++; $display("FAIL random_narrow run %0d edge %0d: got %h want %h", r, k, on, exp[3:0]);
                end
                exp = model(k, 2, 32'h4000_0000, 32);
                tests++;
                if (ob !== exp) begin
                    fails++; $display("FAIL random_step run %0d edge %0d: got %h want %h", r, k, ob, exp);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_count();
        test_div1();
        test_wrap();
        test_mid_run_reset();
        test_random_runs();
        test_default_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
